// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared UART definitions used by both the receiver and the transmitter.
//   - UART_CLKS_PER_BIT : default bit period in clk cycles (must match on
//                         both sides of the link)
//   - UART_DATA_W       : payload width of one frame
//   - rx_state_e        : receiver FSM state encoding
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 16;
  localparam int UART_DATA_W       = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
//   Two-flop synchronizer for a single asynchronous input. Reset loads
//   RESET_VAL into both stages so an idle-high line does not look like an
//   edge coming out of reset.
//
//   Ports:
//     clk  in   system clock
//     rst  in   asynchronous, active-high reset
//     d    in   asynchronous input
//     q    out  synchronized copy of d (two clk cycles of latency)
// ---------------------------------------------------------------------------
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge value of its neighbours; with = the two stages would
  // collapse into one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver: idle-high line, start bit, 8 data bits LSB first,
//   one stop bit. The serial input is synchronized, the start bit is
//   re-checked at mid-bit, every bit is sampled at mid-bit and a good byte
//   is delivered with a one-cycle data_valid pulse.
//
//   Optional feature (macro UART_RX_MAJORITY_EN):
//     defined   - the sample value is the 2-of-3 majority of rx_s over the
//                 three cycles ending at the sample point, rejecting a
//                 single-cycle glitch there.
//     undefined - the sample value is rx_s at the sample point.
//   Timing is identical in both builds.
//
//   Ports:
//     clk         in   system clock
//     rst         in   asynchronous, active-high reset
//     rx          in   serial input, asynchronous, idle high
//     data_out    out  last correctly received byte, held until next good frame
//     data_valid  out  one-cycle pulse: data_out updated this cycle
//     frame_err   out  one-cycle pulse: stop bit sampled low, byte discarded
//     busy        out  high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  output logic [UART_DATA_W-1:0] data_out,
  output logic                   data_valid,
  output logic                   frame_err,
  output logic                   busy
);

  localparam int                BAUD_W   = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_MID = BAUD_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_e              state;
  logic [BAUD_W-1:0]      baud_cnt;
  logic [2:0]             bit_cnt;
  logic [UART_DATA_W-1:0] shift_reg;
  logic                   rx_s;
  logic                   sample;

  // -------------------------------------------------------------------------
  // Input synchronizer (idle-high reset value)
  // -------------------------------------------------------------------------
  uart_rx_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // -------------------------------------------------------------------------
  // Sample value
  // -------------------------------------------------------------------------
`ifdef UART_RX_MAJORITY_EN
  // Two stored values plus the live rx_s form the 3-cycle window ending at
  // the sample point, so the decision lands on the same edge as the plain
  // build.
  logic [1:0] hist;
  logic [2:0] window;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= 2'b11;
    end else begin
      hist <= {hist[0], rx_s};
    end
  end

  assign window = {hist, rx_s};
  assign sample = (window[0] & window[1]) |
                  (window[0] & window[2]) |
                  (window[1] & window[2]);
`else
  assign sample = rx_s;
`endif

  // -------------------------------------------------------------------------
  // Receive FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      // NOTE: shift_reg is an ordinary 8-bit register, not a memory, so it
      // is cleared with the rest of the state; a partial byte must never
      // survive a reset.
      shift_reg  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      // Pulses default low and are raised only in the cycle of the event.
      data_valid <= 1'b0;
      frame_err  <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            baud_cnt <= '0;
          end
        end

        // Re-check the start bit at its middle; a high sample is a glitch.
        START: begin
          if (baud_cnt == BAUD_MID) begin
            baud_cnt <= '0;
            if (!sample) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        // Counting a full bit period from mid-start lands on mid-data.
        DATA: begin
          if (baud_cnt == BAUD_MAX) begin
            baud_cnt           <= '0;
            shift_reg[bit_cnt] <= sample;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        // Leaving at mid-stop gives half a bit of slack to catch a
        // back-to-back start edge.
        STOP: begin
          if (baud_cnt == BAUD_MAX) begin
            baud_cnt <= '0;
            if (sample) begin
              data_out   <= shift_reg;
              data_valid <= 1'b1;
              state      <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HI;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        // A held-low line (break) must return high before a new start
        // can be recognised.
        WAIT_HI: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end

        // NOTE: the default arm recovers from unused encodings; in a
        // clocked block a missing branch only holds state, but in
        // combinational logic it would infer a latch.
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//   Directed self-checking bench for uart_rx at the default bit period.
//   Inputs change 1 time unit after a rising edge; outputs are observed on
//   the falling edge. cyc counts rising edges, so a pulse registered on
//   edge N is seen at the falling edge where cyc == N. A frame whose start
//   bit is driven just after edge E_s has t0 = E_s + 1, so its pulse is
//   expected at cyc == E_s + 155.
// ---------------------------------------------------------------------------
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = UART_CLKS_PER_BIT;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  int         valid_cyc[$];
  logic [7:0] valid_dat[$];
  int         ferr_cyc[$];
  int         both_cnt = 0;
  logic       busy_at_valid = 1'b1;

  uart_rx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor
  always @(negedge clk) begin
    if (data_valid) begin
      valid_cyc.push_back(cyc);
      valid_dat.push_back(data_out);
      busy_at_valid = busy;
    end
    if (frame_err) ferr_cyc.push_back(cyc);
    if (data_valid && frame_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame starting now (caller is 1 unit after a rising edge).
  // glitch_bit selects a data bit that gets a one-cycle inversion exactly
  // at its sample point; -1 means no glitch. rx is left at the stop value.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit,
                           input int glitch_bit, output int e_s);
    e_s = cyc;
    rx  = 1'b0;
    repeat (CPB) tick();
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      if (k == glitch_bit) begin
        repeat (CPB / 2) tick();
        rx = ~b[k];
        tick();
        rx = b[k];
        repeat (CPB / 2 - 1) tick();
      end else begin
        repeat (CPB) tick();
      end
    end
    rx = stop_bit;
    repeat (CPB) tick();
  endtask

  initial begin
    int es;
    int es2;
    logic [7:0] glitch_exp;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) tick();
    check("reset data_out",   32'(data_out),   32'h00);
    check("reset data_valid", 32'(data_valid), 32'h0);
    check("reset frame_err",  32'(frame_err),  32'h0);
    check("reset busy",       32'(busy),       32'h0);
    rst = 1'b0;
    repeat (5) tick();

    // 1) single good frame 0xA5
    send_byte(8'hA5, 1'b1, -1, es);
    repeat (20) tick();
    check("a5 pulse count",  32'(valid_cyc.size()), 32'd1);
    if (valid_cyc.size() >= 1) begin
      check("a5 pulse cycle", 32'(valid_cyc[0]), 32'(es + 155));
      check("a5 pulse data",  32'(valid_dat[0]), 32'hA5);
    end
    check("a5 busy at pulse", 32'(busy_at_valid),  32'h0);
    check("a5 no frame_err",  32'(ferr_cyc.size()), 32'd0);
    check("a5 data_out held", 32'(data_out),        32'hA5);

    // 2) back-to-back 0x3C, 0xC3
    valid_cyc.delete();
    valid_dat.delete();
    send_byte(8'h3C, 1'b1, -1, es);
    send_byte(8'hC3, 1'b1, -1, es2);
    repeat (20) tick();
    check("b2b pulse count", 32'(valid_cyc.size()), 32'd2);
    if (valid_cyc.size() >= 2) begin
      check("b2b first cycle", 32'(valid_cyc[0]), 32'(es + 155));
      check("b2b spacing",     32'(valid_cyc[1] - valid_cyc[0]), 32'd160);
      check("b2b first data",  32'(valid_dat[0]), 32'h3C);
      check("b2b second data", 32'(valid_dat[1]), 32'hC3);
    end

    // 3) 4-cycle low glitch: START aborts, no pulses
    es = cyc;
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (2) tick();
    check("glitch busy in start", 32'(busy), 32'h1);
    repeat (20) tick();
    check("glitch busy dropped", 32'(busy), 32'h0);
    check("glitch no valid",     32'(valid_cyc.size()), 32'd2);
    check("glitch no frame_err", 32'(ferr_cyc.size()),  32'd0);

    // 4) 0x55 with low stop bit held low 40 cycles
    send_byte(8'h55, 1'b0, -1, es);
    repeat (40 - CPB) tick();
    check("ferr pulse count", 32'(ferr_cyc.size()), 32'd1);
    if (ferr_cyc.size() >= 1)
      check("ferr pulse cycle", 32'(ferr_cyc[0]), 32'(es + 155));
    check("ferr no valid",      32'(valid_cyc.size()), 32'd2);
    check("ferr data_out kept", 32'(data_out), 32'hC3);
    check("ferr busy while low", 32'(busy), 32'h1);
    rx = 1'b1;
    repeat (5) tick();
    check("ferr busy after high", 32'(busy), 32'h0);
    repeat (200) tick();
    check("ferr no spurious valid", 32'(valid_cyc.size()), 32'd2);
    check("ferr no spurious ferr",  32'(ferr_cyc.size()),  32'd1);

    // 5) reset during data bit 4 of 0xFF, then 0x12
    rx = 1'b0;
    repeat (CPB) tick();
    rx = 1'b1;
    repeat (4 * CPB + CPB / 2) tick();
    check("pre-reset busy", 32'(busy), 32'h1);
    rst = 1'b1;
    repeat (2) tick();
    check("midframe reset busy",     32'(busy),     32'h0);
    check("midframe reset data_out", 32'(data_out), 32'h00);
    rst = 1'b0;
    repeat (CPB * 6) tick();
    check("aborted frame no valid", 32'(valid_cyc.size()), 32'd2);
    send_byte(8'h12, 1'b1, -1, es);
    repeat (20) tick();
    check("post-reset pulse count", 32'(valid_cyc.size()), 32'd3);
    if (valid_cyc.size() >= 3) begin
      check("post-reset data",  32'(valid_dat[2]), 32'h12);
      check("post-reset cycle", 32'(valid_cyc[2]), 32'(es + 155));
    end

    // 6) 0x00 with a one-cycle high glitch at the bit-2 sample point
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'h00;
`else
    glitch_exp = 8'h04;
`endif
    send_byte(8'h00, 1'b1, 2, es);
    repeat (20) tick();
    check("sample glitch pulse count", 32'(valid_cyc.size()), 32'd4);
    if (valid_cyc.size() >= 4)
      check("sample glitch data", 32'(valid_dat[3]), 32'(glitch_exp));

    check("valid and frame_err exclusive", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
